axi4lite_apb_bridge_mux: RTL and testbench

Parametrised AXI4-Lite slave to multi-slave APB master bridge. Accepts single-beat AXI4-Lite reads and writes and decodes the address onto one of `NUM_SLAVES` APB select lines. Runs an APB SETUP/ACCESS sequence per transaction and returns OKAY, SLVERR or DECERR responses. Replaces the single-slave converter between the AXI4-Lite interconnect and the peripheral APB segment, adding fair read/write arbitration and a per-access timeout.

---
 rtl/axi4lite_apb_bridge_mux_if.sv | 54 +++++
 rtl/axi4lite_apb_bridge_mux.sv | 218 +++++++++++++++++++++
 tb/tb_axi4lite_apb_bridge_mux.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4lite_apb_bridge_mux_if.sv
// Bus bundle between an AXI4-Lite master, the bridge and the APB slave segment.
interface axi4lite_apb_bridge_mux_if #(
   parameter int unsigned dataWidth  = 32,
   parameter int unsigned addrWidth  = 32,
   parameter int unsigned NUM_SLAVES = 4
);
   localparam int unsigned STRB_W = dataWidth / 8;

   logic [addrWidth-1:0]            awaddr;
   logic [2:0]                      awprot;
   logic                            awvalid;
   logic                            awready;
   logic [dataWidth-1:0]            wdata;
   logic [STRB_W-1:0]               wstrb;
   logic                            wvalid;
   logic                            wready;
   logic [1:0]                      bresp;
   logic                            bvalid;
   logic                            bready;
   logic [addrWidth-1:0]            araddr;
   logic [2:0]                      arprot;
   logic                            arvalid;
   logic                            arready;
   logic [dataWidth-1:0]            rdata;
   logic [1:0]                      rresp;
   logic                            rvalid;
   logic                            rready;
   logic [NUM_SLAVES-1:0]           psel;
   logic                            penable;
   logic                            pwrite;
   logic [addrWidth-1:0]            paddr;
   logic [dataWidth-1:0]            pwdata;
   logic [STRB_W-1:0]               pstrb;
   logic [2:0]                      pprot;
   logic [NUM_SLAVES*dataWidth-1:0] prdata;
   logic [NUM_SLAVES-1:0]           pready;
   logic [NUM_SLAVES-1:0]           pslverr;

   // Bridge side: AXI4-Lite slave, APB master.
   modport slave (
      input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready, prdata, pready, pslverr,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
             psel, penable, pwrite, paddr, pwdata, pstrb, pprot
   );

   // Environment side: AXI4-Lite master plus the APB slaves.
   modport master (
      output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready, prdata, pready, pslverr,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid,
             psel, penable, pwrite, paddr, pwdata, pstrb, pprot
   );
endinterface

// File: rtl/axi4lite_apb_bridge_mux.sv
// AXI4-Lite slave to multi-slave APB master bridge with fair read/write
// arbitration, address decode onto one-hot psel and a per-access timeout.
module axi4lite_apb_bridge_mux #(
   parameter int unsigned     dataWidth       = 32,
   parameter int unsigned     addrWidth       = 32,
   parameter int unsigned     NUM_SLAVES      = 4,
   parameter int unsigned     SLAVE_ADDR_BITS = 12,
   parameter longint unsigned BASE_ADDR       = 0,
   parameter int unsigned     TIMEOUT         = 16
) (
   input  logic                        clk,
   input  logic                        resetn,
   axi4lite_apb_bridge_mux_if.slave    bus
);
   localparam int unsigned STRB_W = dataWidth / 8;
   localparam int unsigned LOG2N  = $clog2(NUM_SLAVES);
   localparam int unsigned IDX_W  = (LOG2N > 0) ? LOG2N : 1;
   localparam int unsigned HI_LSB = SLAVE_ADDR_BITS + LOG2N;
   localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [addrWidth-1:0] BASE     = addrWidth'(BASE_ADDR);
   localparam logic [addrWidth-1:0] IDX_MASK = addrWidth'(NUM_SLAVES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                state;
   logic [addrWidth-1:0]  aw_addr;
   logic [2:0]            aw_prot;
   logic                  aw_full;
   logic [dataWidth-1:0]  w_data;
   logic [STRB_W-1:0]     w_strb;
   logic                  w_full;
   logic [addrWidth-1:0]  ar_addr;
   logic [2:0]            ar_prot;
   logic                  ar_full;
   logic                  cur_write;
   logic                  last_write;
   logic [CNT_W-1:0]      cnt;

   logic                  wr_pend;
   logic                  rd_pend;
   logic                  pick_write;
   logic [addrWidth-1:0]  pick_addr;
   logic [2:0]            pick_prot;
   logic                  in_range;
   logic [IDX_W-1:0]      pick_idx;
   logic                  sel_ready;
   logic                  sel_err;
   logic [dataWidth-1:0]  sel_rdata;
   logic [CNT_W-1:0]      cnt_inc;
   logic                  timed_out;
   logic                  acc_done;
   logic [1:0]            acc_resp;
   logic [dataWidth-1:0]  acc_data;
   logic                  b_hs;
   logic                  r_hs;

   assign bus.awready = !aw_full;
   assign bus.wready  = !w_full;
   assign bus.arready = !ar_full;

   assign b_hs = bus.bvalid & bus.bready;
   assign r_hs = bus.rvalid & bus.rready;

   // Arbitration and decode of the request presented in IDLE.
   always_comb begin
      wr_pend    = aw_full & w_full;
      rd_pend    = ar_full;
      pick_write = wr_pend && (!rd_pend || !last_write);
      pick_addr  = pick_write ? aw_addr : ar_addr;
      pick_prot  = pick_write ? aw_prot : ar_prot;
      in_range   = (pick_addr >> HI_LSB) == (BASE >> HI_LSB);
      pick_idx   = IDX_W'((pick_addr >> SLAVE_ADDR_BITS) & IDX_MASK);
   end

   // Selected-slave view of the APB return path; psel is one-hot during ACCESS.
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (bus.psel[i]) begin
            sel_ready = sel_ready | bus.pready[i];
            sel_err   = sel_err | bus.pslverr[i];
            sel_rdata = sel_rdata | bus.prdata[i*dataWidth +: dataWidth];
         end
      end
   end

   // ACCESS completion: slave ready (OKAY/SLVERR) or timeout abort (SLVERR, zero data).
   always_comb begin
      cnt_inc   = cnt + CNT_W'(1);
      timed_out = (TIMEOUT != 0) && !sel_ready && (cnt_inc == CNT_W'(TIMEOUT));
      acc_done  = sel_ready || timed_out;
      acc_resp  = (!sel_ready || sel_err) ? 2'b10 : 2'b00;
      acc_data  = (sel_ready && !sel_err) ? sel_rdata : '0;
   end

   // AW/W/AR holding registers: fill on handshake, drain on the matching response.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         aw_full <= 1'b0;
         aw_addr <= '0;
         aw_prot <= '0;
         w_full  <= 1'b0;
         w_data  <= '0;
         w_strb  <= '0;
         ar_full <= 1'b0;
         ar_addr <= '0;
         ar_prot <= '0;
      end else begin
         if (!aw_full && bus.awvalid) begin
            aw_full <= 1'b1;
            aw_addr <= bus.awaddr;
            aw_prot <= bus.awprot;
         end else if (b_hs) begin
            aw_full <= 1'b0;
         end
         if (!w_full && bus.wvalid) begin
            w_full <= 1'b1;
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
         end else if (b_hs) begin
            w_full <= 1'b0;
         end
         if (!ar_full && bus.arvalid) begin
            ar_full <= 1'b1;
            ar_addr <= bus.araddr;
            ar_prot <= bus.arprot;
         end else if (r_hs) begin
            ar_full <= 1'b0;
         end
      end
   end

   // Transaction FSM with registered APB and AXI response outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         cur_write   <= 1'b0;
         last_write  <= 1'b0;
         cnt         <= '0;
         bus.psel    <= '0;
         bus.penable <= 1'b0;
         bus.pwrite  <= 1'b0;
         bus.paddr   <= '0;
         bus.pwdata  <= '0;
         bus.pstrb   <= '0;
         bus.pprot   <= '0;
         bus.bvalid  <= 1'b0;
         bus.bresp   <= '0;
         bus.rvalid  <= 1'b0;
         bus.rresp   <= '0;
         bus.rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (wr_pend || rd_pend) begin
                  cur_write <= pick_write;
                  if (in_range) begin
                     state       <= SETUP;
                     cnt         <= '0;
                     bus.psel    <= NUM_SLAVES'(1) << pick_idx;
                     bus.penable <= 1'b0;
                     bus.pwrite  <= pick_write;
                     bus.paddr   <= pick_addr;
                     bus.pprot   <= pick_prot;
                     bus.pwdata  <= pick_write ? w_data : '0;
                     bus.pstrb   <= pick_write ? w_strb : '0;
                  end else begin
                     state <= RESP;
                     if (pick_write) begin
                        bus.bvalid <= 1'b1;
                        bus.bresp  <= 2'b11;
                     end else begin
                        bus.rvalid <= 1'b1;
                        bus.rresp  <= 2'b11;
                        bus.rdata  <= '0;
                     end
                  end
               end
            end
            SETUP: begin
               bus.penable <= 1'b1;
               state       <= ACCESS;
            end
            ACCESS: begin
               if (acc_done) begin
                  state       <= RESP;
                  bus.psel    <= '0;
                  bus.penable <= 1'b0;
                  if (cur_write) begin
                     bus.bvalid <= 1'b1;
                     bus.bresp  <= acc_resp;
                  end else begin
                     bus.rvalid <= 1'b1;
                     bus.rresp  <= acc_resp;
                     bus.rdata  <= acc_data;
                  end
               end else begin
                  cnt <= cnt_inc;
               end
            end
            RESP: begin
               if (cur_write && b_hs) begin
                  bus.bvalid <= 1'b0;
                  last_write <= 1'b1;
                  state      <= IDLE;
               end else if (!cur_write && r_hs) begin
                  bus.rvalid <= 1'b0;
                  last_write <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4lite_apb_bridge_mux.sv
// Self-checking bench for axi4lite_apb_bridge_mux: AXI master tasks, a small
// APB slave model and scoreboards for APB setups and AXI responses.
module tb_axi4lite_apb_bridge_mux;
   logic clk;
   logic resetn;
   int   total;
   int   bad;
   int   cyc;

   typedef struct {
      logic [3:0]  psel;
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [2:0]  prot;
      int          acc;
   } apb_t;

   typedef struct {
      logic [1:0]  resp;
      logic [31:0] data;
      int          lat;
      int          hs;
   } rsp_t;

   apb_t apbq[$];
   rsp_t bq[$];
   rsp_t rq[$];
   int   b_push, b_pop, r_push, r_pop;

   // APB slave model configuration
   int          wait_cfg[4];
   logic        hang[4];
   logic        err[4];
   logic [31:0] data_cfg[4];
   int          scnt[4];

   axi4lite_apb_bridge_mux_if #(.dataWidth(32), .addrWidth(32), .NUM_SLAVES(4)) bus ();

   axi4lite_apb_bridge_mux #(
      .dataWidth(32), .addrWidth(32), .NUM_SLAVES(4),
      .SLAVE_ADDR_BITS(12), .BASE_ADDR(0), .TIMEOUT(16)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign bus.prdata = {data_cfg[3], data_cfg[2], data_cfg[1], data_cfg[0]};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // APB slaves: ready after wait_cfg ACCESS cycles unless hung.
   always @(negedge clk) begin
      logic [3:0] rdy;
      logic [3:0] ev;
      rdy = '0;
      ev  = '0;
      for (int i = 0; i < 4; i++) begin
         if (bus.psel[i] && bus.penable) begin
            if (!hang[i] && scnt[i] >= wait_cfg[i]) begin
               rdy[i] = 1'b1;
               ev[i]  = err[i];
            end
            scnt[i]++;
         end else begin
            scnt[i] = 0;
         end
      end
      bus.pready  = rdy;
      bus.pslverr = ev;
   end

   // APB monitor: checks each SETUP against the expected queue and counts ACCESS cycles.
   apb_t cur;
   logic in_xfer;
   int   acc;
   always @(negedge clk) begin
      if (!resetn) begin
         in_xfer = 1'b0;
      end else begin
         if (bus.psel != 0 && !bus.penable) begin
            if (apbq.size() == 0) begin
               check("apb_unexp", 64'(bus.psel), 64'h0);
            end else begin
               cur = apbq.pop_front();
               check("psel", 64'(bus.psel), 64'(cur.psel));
               check("paddr", 64'(bus.paddr), 64'(cur.addr));
               check("pwrite", 64'(bus.pwrite), 64'(cur.write));
               check("pwdata", 64'(bus.pwdata), 64'(cur.wdata));
               check("pstrb", 64'(bus.pstrb), 64'(cur.strb));
               check("pprot", 64'(bus.pprot), 64'(cur.prot));
               in_xfer = 1'b1;
               acc     = 0;
            end
         end
         if (bus.psel != 0 && bus.penable) acc++;
         if (bus.psel == 0 && in_xfer) begin
            in_xfer = 1'b0;
            if (cur.acc >= 0) check("penable_cycles", 64'(acc), 64'(cur.acc));
         end
      end
   end

   // Response monitor: pops the scoreboard on each B/R handshake.
   logic b_prev, r_prev;
   int   b_rise, r_rise;
   always @(negedge clk) begin
      rsp_t e;
      if (bus.bvalid && !b_prev) b_rise = cyc;
      if (bus.rvalid && !r_prev) r_rise = cyc;
      b_prev = bus.bvalid;
      r_prev = bus.rvalid;
      if (resetn && bus.bvalid && bus.bready) begin
         if (bq.size() == 0) begin
            check("b_unexp", 64'(bus.bvalid), 64'h0);
         end else begin
            e = bq.pop_front();
            check("bresp", 64'(bus.bresp), 64'(e.resp));
            if (e.lat >= 0) check("b_latency", 64'(b_rise - e.hs), 64'(e.lat));
         end
         b_pop++;
      end
      if (resetn && bus.rvalid && bus.rready) begin
         if (rq.size() == 0) begin
            check("r_unexp", 64'(bus.rvalid), 64'h0);
         end else begin
            e = rq.pop_front();
            check("rresp", 64'(bus.rresp), 64'(e.resp));
            check("rdata", 64'(bus.rdata), 64'(e.data));
            if (e.lat >= 0) check("r_latency", 64'(r_rise - e.hs), 64'(e.lat));
         end
         r_pop++;
      end
   end

   task automatic exp_apb(input logic [3:0] psel, input logic [31:0] addr, input logic write,
                          input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot,
                          input int acc_n);
      apbq.push_back('{psel, addr, write, wdata, strb, prot, acc_n});
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp, input int lat);
      logic aw_ok, w_ok, aw_now, w_now;
      int   id, n;
      bus.awaddr = addr; bus.awprot = prot; bus.awvalid = 1'b1;
      bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
      aw_ok = 1'b0; w_ok = 1'b0; n = 0;
      while (!(aw_ok && w_ok) && n < 100) begin
         aw_now = bus.awvalid && bus.awready;
         w_now  = bus.wvalid && bus.wready;
         @(posedge clk); #1;
         if (aw_now) begin aw_ok = 1'b1; bus.awvalid = 1'b0; end
         if (w_now)  begin w_ok = 1'b1;  bus.wvalid = 1'b0; end
         n++;
      end
      if (!(aw_ok && w_ok)) begin
         check("aw_w_handshake", 64'({aw_ok, w_ok}), 64'h3);
         bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      end else begin
         id = b_push++;
         bq.push_back('{resp, 32'h0, lat, cyc});
         for (n = 0; n < 200 && b_pop <= id; n++) @(posedge clk);
         #1;
         if (b_pop <= id) check("b_wait", 64'(b_pop), 64'(id + 1));
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot, input logic [1:0] resp,
                           input logic [31:0] data, input int lat, input int hold);
      logic ar_now, ok;
      int   id, n;
      bus.araddr = addr; bus.arprot = prot; bus.arvalid = 1'b1;
      if (hold > 0) bus.rready = 1'b0;
      ok = 1'b0; n = 0;
      while (!ok && n < 100) begin
         ar_now = bus.arvalid && bus.arready;
         @(posedge clk); #1;
         if (ar_now) begin ok = 1'b1; bus.arvalid = 1'b0; end
         n++;
      end
      if (!ok) begin
         check("ar_handshake", 64'(ok), 64'h1);
         bus.arvalid = 1'b0; bus.rready = 1'b1;
      end else begin
         id = r_push++;
         rq.push_back('{resp, data, lat, cyc});
         if (hold > 0) begin
            for (n = 0; n < 100 && !bus.rvalid; n++) begin @(posedge clk); #1; end
            repeat (hold) begin
               @(posedge clk); #1;
               check("r_hold_valid", 64'(bus.rvalid), 64'h1);
            end
            bus.rready = 1'b1;
         end
         for (n = 0; n < 200 && r_pop <= id; n++) @(posedge clk);
         #1;
         if (r_pop <= id) check("r_wait", 64'(r_pop), 64'(id + 1));
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      int n;
      total = 0; bad = 0; cyc = 0;
      b_push = 0; b_pop = 0; r_push = 0; r_pop = 0;
      b_prev = 1'b0; r_prev = 1'b0; b_rise = 0; r_rise = 0;
      in_xfer = 1'b0; acc = 0;
      for (int i = 0; i < 4; i++) begin
         wait_cfg[i] = 0; hang[i] = 1'b0; err[i] = 1'b0; scnt[i] = 0;
         data_cfg[i] = 32'hA5A5_0000 | 32'(i);
      end
      resetn = 1'b0;
      bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
      bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      // Reset values
      check("rst_psel", 64'(bus.psel), 64'h0);
      check("rst_penable", 64'(bus.penable), 64'h0);
      check("rst_bvalid", 64'(bus.bvalid), 64'h0);
      check("rst_rvalid", 64'(bus.rvalid), 64'h0);
      check("rst_paddr", 64'(bus.paddr), 64'h0);
      check("rst_rdata", 64'(bus.rdata), 64'h0);
      check("rst_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
      resetn = 1'b1;
      @(posedge clk); #1;

      // Zero-wait write to slave 1
      exp_apb(4'b0010, 32'h0000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'b001, 1);
      axi_write(32'h0000_1004, 3'b001, 32'hDEAD_BEEF, 4'hF, 2'b00, 3);

      // Read from slave 3 with two wait states, response held under back-pressure
      wait_cfg[3] = 2; data_cfg[3] = 32'h1234_5678;
      exp_apb(4'b1000, 32'h0000_3010, 1'b0, 32'h0, 4'h0, 3'b010, 3);
      axi_read(32'h0000_3010, 3'b010, 2'b00, 32'h1234_5678, 5, 2);
      wait_cfg[3] = 0;

      // Arbitration tie from reset: write first, then read
      do_reset();
      exp_apb(4'b0001, 32'h0000_0008, 1'b1, 32'h1111_2222, 4'h3, 3'b000, 1);
      exp_apb(4'b0100, 32'h0000_2000, 1'b0, 32'h0, 4'h0, 3'b000, 1);
      fork
         axi_write(32'h0000_0008, 3'b000, 32'h1111_2222, 4'h3, 2'b00, -1);
         axi_read(32'h0000_2000, 3'b000, 2'b00, 32'hA5A5_0002, -1, 0);
      join
      // Lone write leaves write as last served; the next tie goes to the read
      exp_apb(4'b0010, 32'h0000_1100, 1'b1, 32'h3333_4444, 4'hC, 3'b000, 1);
      axi_write(32'h0000_1100, 3'b000, 32'h3333_4444, 4'hC, 2'b00, 3);
      exp_apb(4'b0001, 32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'b000, 1);
      exp_apb(4'b1000, 32'h0000_3200, 1'b1, 32'h5555_6666, 4'hF, 3'b000, 1);
      fork
         axi_write(32'h0000_3200, 3'b000, 32'h5555_6666, 4'hF, 2'b00, -1);
         axi_read(32'h0000_0100, 3'b000, 2'b00, 32'hA5A5_0000, -1, 0);
      join

      // Decode errors: no APB activity, DECERR one cycle after handshake
      axi_write(32'h0001_0000, 3'b000, 32'h0BAD_0BAD, 4'hF, 2'b11, 1);
      axi_read(32'h0001_0000, 3'b000, 2'b11, 32'h0, 1, 0);

      // Slave error with ready
      err[2] = 1'b1;
      exp_apb(4'b0100, 32'h0000_2004, 1'b0, 32'h0, 4'h0, 3'b000, 1);
      axi_read(32'h0000_2004, 3'b000, 2'b10, 32'h0, 3, 0);
      exp_apb(4'b0100, 32'h0000_2008, 1'b1, 32'h7777_8888, 4'h1, 3'b000, 1);
      axi_write(32'h0000_2008, 3'b000, 32'h7777_8888, 4'h1, 2'b10, 3);
      err[2] = 1'b0;

      // Timeout on a hung slave: 16 ACCESS cycles, SLVERR, zero data
      hang[1] = 1'b1;
      exp_apb(4'b0010, 32'h0000_1008, 1'b0, 32'h0, 4'h0, 3'b000, 16);
      axi_read(32'h0000_1008, 3'b000, 2'b10, 32'h0, 18, 0);
      hang[1] = 1'b0;

      // Reset in the middle of ACCESS
      hang[0] = 1'b1;
      exp_apb(4'b0001, 32'h0000_0010, 1'b1, 32'hCAFE_0001, 4'hF, 3'b000, -1);
      bus.awaddr = 32'h0000_0010; bus.awprot = 3'b000; bus.awvalid = 1'b1;
      bus.wdata = 32'hCAFE_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      @(posedge clk); #1;
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      for (n = 0; n < 20 && !bus.penable; n++) begin @(posedge clk); #1; end
      check("mid_penable_seen", 64'(bus.penable), 64'h1);
      @(posedge clk); #2;
      resetn = 1'b0;
      #1;
      check("mid_psel", 64'(bus.psel), 64'h0);
      check("mid_penable", 64'(bus.penable), 64'h0);
      check("mid_bvalid", 64'(bus.bvalid), 64'h0);
      check("mid_readies", 64'({bus.awready, bus.wready, bus.arready}), 64'h7);
      hang[0] = 1'b0;
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      exp_apb(4'b0001, 32'h0000_0020, 1'b1, 32'hCAFE_0002, 4'hF, 3'b000, 1);
      axi_write(32'h0000_0020, 3'b000, 32'hCAFE_0002, 4'hF, 2'b00, 3);

      repeat (3) @(posedge clk);
      #1;
      check("apbq_empty", 64'(apbq.size()), 64'h0);
      check("bq_empty", 64'(bq.size()), 64'h0);
      check("rq_empty", 64'(rq.size()), 64'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
